tiny_riscv_lsu: RTL and testbench

Load/store unit for the tiny RISC-V core. It sits directly downstream of the core's execute stage and upstream of the data RAM. It accepts one LOAD/STORE request at a time and converts it into a word-aligned memory access with byte-lane write masks. For loads it returns the extracted, sign- or zero-extended result, and it reports illegal, misaligned and timed-out accesses as errors.

---
 rtl/tiny_riscv_pkg.sv | 47 ++++
 rtl/tiny_riscv_lsu_if.sv | 31 +++
 rtl/tiny_riscv_lsu_align.sv | 51 +++++
 rtl/tiny_riscv_lsu.sv | 131 +++++++++++++
 tb/tb_tiny_riscv_lsu.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tiny_riscv_pkg.sv
// Shared definitions for the tiny RISC-V core: funct3 / opcode constants,
// LSU state encoding, the latched request payload and decode helpers.
package tiny_riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_ISSUE = 2'd1,
        LSU_WAIT  = 2'd2,
        LSU_RESP  = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

    // Stores only have B/H/W; loads add the unsigned B/H variants.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tiny_riscv_lsu_if.sv
// Core request/response and data-RAM bus of the LSU.
// master: the core and RAM side; slave: the LSU itself.
interface tiny_riscv_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wdata, mem_wmask, mem_rstrb
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wdata, mem_wmask, mem_rstrb
    );
endinterface

// File: rtl/tiny_riscv_lsu_align.sv
// Byte-lane steering: store mask / replicated data and load extraction.
// Offsets are forced to natural alignment for the access size.
module tiny_riscv_lsu_align
    import tiny_riscv_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    input  logic [31:0] ram_word,
    output logic [3:0]  wmask_c,
    output logic [31:0] wdata_c,
    output logic [31:0] load_data_c
);

    logic [1:0]  eff_off;
    logic [31:0] word_sh;

    always_comb begin
        eff_off     = offset;
        wmask_c     = '0;
        wdata_c     = '0;
        load_data_c = '0;
        case (funct3[1:0])
            2'b01:   eff_off = {offset[1], 1'b0};
            2'b10:   eff_off = 2'b00;
            default: ;
        endcase
        word_sh = ram_word >> {eff_off, 3'b000};
        case (funct3)
            F3_B: begin
                wmask_c     = 4'b0001 << eff_off;
                wdata_c     = {4{store_data[7:0]}};
                load_data_c = {{24{word_sh[7]}}, word_sh[7:0]};
            end
            F3_H: begin
                wmask_c     = 4'b0011 << eff_off;
                wdata_c     = {2{store_data[15:0]}};
                load_data_c = {{16{word_sh[15]}}, word_sh[15:0]};
            end
            F3_W: begin
                wmask_c     = 4'b1111;
                wdata_c     = store_data;
                load_data_c = word_sh;
            end
            F3_BU:   load_data_c = {24'h0, word_sh[7:0]};
            F3_HU:   load_data_c = {16'h0, word_sh[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/tiny_riscv_lsu.sv
// Load/store unit: one request at a time, word-aligned RAM access with
// byte-lane masks, timeout abort. Build option: LSU_MISALIGN_TRAP_EN.
module tiny_riscv_lsu
    import tiny_riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic              i_Clk,
    input  logic              i_Rst_N,
    tiny_riscv_lsu_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t       state;
    lsu_req_t         req_q;
    lsu_req_t         req_in;
    lsu_req_t         cur;
    logic [CNT_W-1:0] cnt;

    logic        ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wmask_q;
    logic        mem_rstrb_q;

    logic        accept;
    logic        reject_c;
    logic [3:0]  wmask_c;
    logic [31:0] wdata_c;
    logic [31:0] load_data_c;

    assign req_in = '{we: bus.req_we, funct3: bus.req_funct3,
                      addr: bus.req_addr, wdata: bus.req_wdata};
    // Steer lanes from the incoming request at accept, from the latch afterwards.
    assign cur    = (state == LSU_IDLE) ? req_in : req_q;
    assign accept = bus.req_valid && ready_q;

`ifdef LSU_MISALIGN_TRAP_EN
    assign reject_c = !f3_legal(req_in.we, req_in.funct3) ||
                      is_misaligned(req_in.funct3, req_in.addr[1:0]);
`else
    assign reject_c = !f3_legal(req_in.we, req_in.funct3);
`endif

    tiny_riscv_lsu_align u_align (
        .offset      (cur.addr[1:0]),
        .funct3      (cur.funct3),
        .store_data  (cur.wdata),
        .ram_word    (bus.mem_rdata),
        .wmask_c     (wmask_c),
        .wdata_c     (wdata_c),
        .load_data_c (load_data_c)
    );

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_N) begin
            state       <= LSU_IDLE;
            req_q       <= '0;
            cnt         <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            mem_rstrb_q <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (accept) begin
                        req_q   <= req_in;
                        ready_q <= 1'b0;
                        if (reject_c) begin
                            state       <= LSU_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state       <= LSU_ISSUE;
                            cnt         <= CNT_W'(1);
                            mem_wdata_q <= req_in.we ? wdata_c : '0;
                            mem_wmask_q <= req_in.we ? wmask_c : 4'b0000;
                            mem_rstrb_q <= !req_in.we;
                        end
                    end
                end
                LSU_ISSUE, LSU_WAIT: begin
                    mem_wmask_q <= '0;
                    mem_rstrb_q <= 1'b0;
                    // Ack has priority over a timeout in the same cycle.
                    if (bus.mem_ack) begin
                        state       <= LSU_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= req_q.we ? '0 : load_data_c;
                    end else if (cnt >= CNT_W'(TIMEOUT_CYCLES)) begin
                        state       <= LSU_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        state <= LSU_WAIT;
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                LSU_RESP: begin
                    state       <= LSU_IDLE;
                    ready_q     <= 1'b1;
                    cnt         <= '0;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_addr  = {req_q.addr[31:2], 2'b00};
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wmask = mem_wmask_q;
    assign bus.mem_rstrb = mem_rstrb_q;

endmodule

// File: tb/tb_tiny_riscv_lsu.sv
// Scoreboard bench for tiny_riscv_lsu: directed cases plus random requests
// checked against a byte-level reference model; a RAM model answers strobes.
module tb_tiny_riscv_lsu;
    import tiny_riscv_pkg::*;

    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tiny_riscv_lsu_if bus ();

    tiny_riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .i_Clk   (clk),
        .i_Rst_N (rst_n),
        .bus     (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        rstrb;
        int          cyc;
        logic [31:0] word;
        int          k;
    } mem_exp_t;

    rsp_exp_t rsp_q[$];
    mem_exp_t mem_q[$];
    bit       ram_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not as required (cycle %0d)", name, cyc);
    endtask

    // Reference model: byte arithmetic over the access size and RAM word.
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] word, input int k, input int t,
                                  output rsp_exp_t r, output mem_exp_t m, output bit access);
        int size;
        int lo;
        bit legal;
        bit trap;
        logic [31:0] val;
        size   = 1 << f3[1:0];
        legal  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_TRAP_EN
        trap   = (int'(addr[1:0]) % size) != 0;
`else
        trap   = 1'b0;
`endif
        r.rdata = '0;
        r.err   = 1'b1;
        r.cyc   = t + 1;
        m.addr  = '0; m.wdata = '0; m.wmask = '0; m.rstrb = 1'b0;
        m.cyc   = 0;  m.word  = word; m.k = k;
        access  = 1'b0;
        if (!legal || trap) return;
        access  = 1'b1;
        lo      = (int'(addr[1:0]) / size) * size;
        m.addr  = addr & 32'hFFFF_FFFC;
        m.rstrb = !we;
        m.cyc   = t + 1;
        val     = '0;
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                m.wmask[i]       = (i >= lo) && (i < lo + size);
                m.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
            end
        end else begin
            for (int i = 0; i < size; i++) val[8*i +: 8] = word[8*(lo + i) +: 8];
            if (!f3[2] && size < 4 && val[8*size-1]) begin
                for (int i = 8*size; i < 32; i++) val[i] = 1'b1;
            end
        end
        if (k < 0 || k >= TO) begin
            r.cyc = t + 1 + TO;
        end else begin
            r.err   = 1'b0;
            r.rdata = we ? 32'h0 : val;
            r.cyc   = t + 2 + k;
        end
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] word, input int k);
        int budget;
        rsp_exp_t r;
        mem_exp_t m;
        bit acc;
        budget = 0;
        while ((rsp_q.size() != 0 || mem_q.size() != 0 || ram_busy) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) fail("idle_wait_budget");
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        budget = 0;
        while (!bus.req_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            fail("accept_budget");
            bus.req_valid = 1'b0;
            return;
        end
        model(we, f3, addr, wdata, word, k, cyc, r, m, acc);
        rsp_q.push_back(r);
        if (acc) mem_q.push_back(m);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        bus.req_funct3 = 3'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},     32'(bus.req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata,      32'd0);
        check({tag, "_mem_addr"},  bus.mem_addr,       32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
        check({tag, "_strobes"},   32'({bus.mem_rstrb, bus.mem_wmask}), 32'd0);
    endtask

    // Response monitor: pops the scoreboard on each response pulse.
    initial begin
        rsp_exp_t r;
        bit chk_ready;
        chk_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_ready && rst_n) check("ready_after_rsp", 32'(bus.req_ready), 32'd1);
            chk_ready = 1'b0;
            if (rst_n && bus.rsp_valid === 1'b1) begin
                if (rsp_q.size() == 0) begin
                    fail("unexpected_rsp");
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_rdata", bus.rsp_rdata, r.rdata);
                    check("rsp_err",   32'(bus.rsp_err), 32'(r.err));
                    check("rsp_cycle", 32'(cyc), 32'(r.cyc));
                    chk_ready = 1'b1;
                end
            end
        end
    end

    // RAM model: checks each strobe, then acks after the planned delay.
    initial begin
        mem_exp_t m;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.mem_rstrb === 1'b1 || bus.mem_wmask !== 4'b0000)) begin
                if (mem_q.size() == 0) begin
                    fail("unexpected_strobe");
                end else begin
                    m = mem_q.pop_front();
                    ram_busy = 1'b1;
                    check("mem_addr",     bus.mem_addr, m.addr);
                    check("mem_rstrb",    32'(bus.mem_rstrb), 32'(m.rstrb));
                    check("mem_wmask",    32'(bus.mem_wmask), 32'(m.wmask));
                    if (!m.rstrb) check("mem_wdata", bus.mem_wdata, m.wdata);
                    check("strobe_cycle", 32'(cyc), 32'(m.cyc));
                    if (m.k == 0) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = m.word;
                    end
                    @(negedge clk);
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                    check("strobe_width", 32'({bus.mem_rstrb, bus.mem_wmask}), 32'd0);
                    if (m.k > 0) begin
                        repeat (m.k - 1) @(negedge clk);
                        check("addr_held", bus.mem_addr, m.addr);
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = m.word;
                        @(negedge clk);
                        bus.mem_ack   = 1'b0;
                        bus.mem_rdata = $urandom;
                    end
                    ram_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        int budget;
        int sel;
        int k;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        do_req(1'b0, F3_B,  32'h0000_0103, 32'h0,         32'h80FF_1234, 0);
        do_req(1'b0, F3_BU, 32'h0000_0103, 32'h0,         32'h80FF_1234, 0);
        do_req(1'b0, F3_HU, 32'h0000_0102, 32'h0,         32'h80FF_1234, 1);
        do_req(1'b0, F3_H,  32'h0000_0102, 32'h0,         32'h80FF_1234, 2);
        do_req(1'b1, F3_H,  32'h0000_0206, 32'hDEAD_BEEF, 32'h0,         0);
        do_req(1'b1, F3_B,  32'h0000_0305, 32'h1234_56A5, 32'h0,         3);
        do_req(1'b1, F3_W,  32'h0000_0308, 32'hCAFE_F00D, 32'h0,         1);
        do_req(1'b0, F3_W,  32'h0000_0101, 32'h0,         32'h1122_3344, 0);
        do_req(1'b0, F3_H,  32'h0000_0107, 32'h0,         32'h8899_AABB, 0);
        do_req(1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,         0);
        do_req(1'b1, F3_BU, 32'h0000_0100, 32'h55,        32'h0,         0);
        do_req(1'b0, F3_W,  32'h0000_0400, 32'h0,         32'h0BAD_CAFE, TO - 1);
        do_req(1'b0, F3_W,  32'h0000_0404, 32'h0,         32'h1357_9BDF, -1);
        do_req(1'b1, F3_W,  32'h0000_0408, 32'h2468_ACE0, 32'h0,         TO + 1);
        do_req(1'b0, F3_B,  32'h0000_040C, 32'h0,         32'h0000_00FF, TO);

        // Reset while the access sits in WAIT; the pending response is dropped.
        do_req(1'b0, F3_W,  32'h0000_0500, 32'h0,         32'h0,         -1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rsp_q.delete();
        rst_n = 1'b1;
        do_req(1'b1, F3_W,  32'h0000_0040, 32'hA5A5_0F0F, 32'h0,         1);

        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                6:       k = TO - 1;
                7:       k = TO;
                8:       k = TO + 1;
                9:       k = -1;
                default: k = sel % 4;
            endcase
            do_req(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, k);
        end

        budget = 0;
        while ((rsp_q.size() != 0 || mem_q.size() != 0 || ram_busy) && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) fail("drain_budget");
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
